conv_mac_stream: RTL and testbench

//  Parametrised successor 2-D convolution MAC engine: computes a KxK window dot product pixel[i]*kernel[i].

---
 rtl/conv_mac_stream.sv | 139 +++++++++++++
 tb/tb_conv_mac_stream.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/conv_mac_stream.sv
// KxK convolution MAC engine: pixel/kernel banks are loaded from a 32-bit valid/ready stream,
// then a one-tap-per-cycle pipelined MAC feeds a saturating or wrapping accumulator.
module conv_mac_stream #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int ACC_W  = 32,
  parameter int SAT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_bank,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             ovf,
  output logic             ker_loaded,
  output logic             busy
);
  localparam int N   = K * K;
  localparam int EPB = 32 / DATA_W;
  localparam int BPB = (N + EPB - 1) / EPB;
  localparam int PW  = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int TW  = (N > 1) ? $clog2(N) : 1;
  localparam int PRW = 2 * DATA_W;

  typedef enum logic [1:0] {LOAD, MAC, DRAIN, OUT} state_t;

  state_t                   state;
  logic [PW-1:0]            pix_ptr, ker_ptr;
  logic                     pix_full;
  logic [TW-1:0]            tap;
  logic signed [PRW-1:0]    prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] pix_mem [N];
  logic signed [DATA_W-1:0] ker_mem [N];

  logic                     pix_acc, ker_acc, pix_last, ker_last;
  logic                     pix_full_n, ker_loaded_n, do_acc, add_ovf;
  logic signed [PRW-1:0]    mult;
  logic signed [ACC_W:0]    sum;
  logic signed [ACC_W-1:0]  acc_n;

  assign in_ready = rst_n & (state == LOAD) & ~(~in_bank & pix_full);
  assign busy     = (state != LOAD);
  assign pix_acc  = in_valid & in_ready & ~in_bank;
  assign ker_acc  = in_valid & in_ready & in_bank;
  assign pix_last = (pix_ptr == PW'(BPB - 1));
  assign ker_last = (ker_ptr == PW'(BPB - 1));

  // Start condition looks at the post-beat bank status so a landing final beat starts MAC at once.
  always_comb begin
    pix_full_n   = pix_full | (pix_acc & pix_last);
    ker_loaded_n = ker_loaded;
    if (ker_acc) begin
      if (ker_last)
        ker_loaded_n = 1'b1;
      else if (ker_ptr == '0)
        ker_loaded_n = 1'b0;
    end
  end

  always_comb begin
    mult    = PRW'(pix_mem[tap]) * PRW'(ker_mem[tap]);
    do_acc  = ((state == MAC) && (tap != '0)) || (state == DRAIN);
    sum     = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - PRW){prod[PRW-1]}}, prod};
    add_ovf = (sum[ACC_W] != sum[ACC_W-1]);
    acc_n   = sum[ACC_W-1:0];
    if (SAT != 0 && add_ovf)
      acc_n = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (pix_acc && pix_ptr == PW'(i / EPB))
        pix_mem[i] <= in_data[(i % EPB) * DATA_W +: DATA_W];
      if (ker_acc && ker_ptr == PW'(i / EPB))
        ker_mem[i] <= in_data[(i % EPB) * DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      pix_ptr    <= '0;
      ker_ptr    <= '0;
      pix_full   <= 1'b0;
      ker_loaded <= 1'b0;
      tap        <= '0;
      prod       <= '0;
      acc        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (do_acc) begin
        acc <= acc_n;
        if (add_ovf) ovf <= 1'b1;
      end
      case (state)
        LOAD: begin
          if (pix_acc) pix_ptr <= pix_last ? '0 : pix_ptr + 1'b1;
          if (ker_acc) ker_ptr <= ker_last ? '0 : ker_ptr + 1'b1;
          pix_full   <= pix_full_n;
          ker_loaded <= ker_loaded_n;
          if (acc_clear) begin
            acc <= '0;
            ovf <= 1'b0;
          end
          if (pix_full_n && ker_loaded_n) begin
            state <= MAC;
            tap   <= '0;
          end
        end
        MAC: begin
          prod <= mult;
          tap  <= tap + 1'b1;
          if (tap == TW'(N - 1)) state <= DRAIN;
        end
        DRAIN: state <= OUT;
        OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= acc;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= LOAD;
            pix_full  <= 1'b0;
            pix_ptr   <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_mac_stream.sv
// Directed bench for conv_mac_stream: default instance plus two 16-bit accumulator
// variants (saturating and wrapping) sharing the same stimulus.
module tb_conv_mac_stream;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_bank, acc_clear, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, ovf, ker_loaded, busy;
  logic [31:0] out_data;
  logic        rdy_s, ov_s, ovf_s, kl_s, busy_s;
  logic [15:0] od_s;
  logic        rdy_w, ov_w, ovf_w, kl_w, busy_w;
  logic [15:0] od_w;
  int          vectors = 0;
  int          errs = 0;
  int          lat;

  always #5 clk = ~clk;

  conv_mac_stream u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_bank(in_bank), .acc_clear(acc_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .ovf(ovf), .ker_loaded(ker_loaded), .busy(busy));

  conv_mac_stream #(.ACC_W(16), .SAT(1)) u_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
    .in_bank(in_bank), .acc_clear(acc_clear), .out_valid(ov_s), .out_ready(out_ready),
    .out_data(od_s), .ovf(ovf_s), .ker_loaded(kl_s), .busy(busy_s));

  conv_mac_stream #(.ACC_W(16), .SAT(0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w), .in_data(in_data),
    .in_bank(in_bank), .acc_clear(acc_clear), .out_valid(ov_w), .out_ready(out_ready),
    .out_data(od_w), .ovf(ovf_w), .ker_loaded(kl_w), .busy(busy_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic bank, input logic [31:0] d);
    int n = 0;
    in_bank  = bank;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_out_valid", {31'b0, out_valid}, 32'd0);
    chk("hs_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic clear_acc();
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bank = 1'b0; acc_clear = 1'b0;
    out_ready = 1'b0; in_data = '0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ker_loaded", {31'b0, ker_loaded}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // 1: kernel 1..9, pixels all 1 -> 45, latency N+2
    send(1'b1, 32'h04030201); send(1'b1, 32'h08070605); send(1'b1, 32'h00000009);
    chk("t1_ker_loaded", {31'b0, ker_loaded}, 32'd1);
    send(1'b0, 32'h01010101); send(1'b0, 32'h01010101); send(1'b0, 32'h01010101);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    wait_out(lat);
    chk("t1_latency", lat, 32'd11);
    chk("t1_out_data", out_data, 32'd45);
    chk("t1_ovf", {31'b0, ovf}, 32'd0);
    handshake();

    // 2: kernel kept, acc accumulates -> 90
    chk("t2_ker_loaded", {31'b0, ker_loaded}, 32'd1);
    send(1'b0, 32'h01010101); send(1'b0, 32'h01010101); send(1'b0, 32'h01010101);
    wait_out(lat);
    chk("t2_out_data", out_data, 32'd90);
    chk("t2_ker_kept", {31'b0, ker_loaded}, 32'd1);
    handshake();

    // 3: all -128 * -128, nine taps: 147456 / saturate / wrap
    clear_acc();
    send(1'b1, 32'h80808080); send(1'b1, 32'h80808080); send(1'b1, 32'h80808080);
    send(1'b0, 32'h80808080); send(1'b0, 32'h80808080); send(1'b0, 32'h80808080);
    wait_out(lat);
    chk("t3_out_data", out_data, 32'd147456);
    chk("t3_ovf", {31'b0, ovf}, 32'd0);
    chk("t3_sat_data", {16'b0, od_s}, 32'h7FFF);
    chk("t3_sat_ovf", {31'b0, ovf_s}, 32'd1);
    chk("t3_wrap_data", {16'b0, od_w}, 32'h4000);
    chk("t3_wrap_ovf", {31'b0, ovf_w}, 32'd1);
    handshake();

    // 4: pixels 1 with kernel -128 -> -1152, output held under back-pressure
    clear_acc();
    send(1'b0, 32'h01010101); send(1'b0, 32'h01010101); send(1'b0, 32'h01010101);
    wait_out(lat);
    in_bank = 1'b0; in_data = 32'h01010101; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("t4_hold_data", out_data, 32'hFFFFFB80);
      chk("t4_stall_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    handshake();

    // 6: reset during MAC tap 4 wipes everything
    send(1'b0, 32'h01010101); send(1'b0, 32'h01010101); send(1'b0, 32'h01010101);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_out_data", out_data, 32'd0);
    chk("t6_ovf", {31'b0, ovf}, 32'd0);
    chk("t6_ker_loaded", {31'b0, ker_loaded}, 32'd0);
    chk("t6_in_ready", {31'b0, in_ready}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_after_ker", {31'b0, ker_loaded}, 32'd0);

    // 5: pixels (-1) first, fourth pixel beat stalls, kernel still accepted -> -45
    send(1'b0, 32'hFFFFFFFF); send(1'b0, 32'hFFFFFFFF); send(1'b0, 32'hFFFFFFFF);
    in_bank = 1'b0; in_data = 32'hFFFFFFFF; in_valid = 1'b1;
    #1;
    chk("t5_pix_stall", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("t5_pix_stall2", {31'b0, in_ready}, 32'd0);
    chk("t5_idle", {31'b0, busy}, 32'd0);
    in_bank = 1'b1;
    #1;
    chk("t5_ker_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    send(1'b1, 32'h04030201); send(1'b1, 32'h08070605); send(1'b1, 32'h00000009);
    chk("t5_busy", {31'b0, busy}, 32'd1);
    wait_out(lat);
    chk("t5_latency", lat, 32'd11);
    chk("t5_out_data", out_data, 32'hFFFFFFD3);
    chk("t5_ovf", {31'b0, ovf}, 32'd0);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
